// File: rtl/mips_pkg.sv
// Shared definitions for the pipeline memory arbiter: FSM state encoding and
// the default bound on consecutive data grants while a fetch is waiting.
package mips_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_IBUSY,
        ARB_DBUSY
    } arb_state_t;

    localparam int STARVE_DEFAULT = 4;

endpackage

// File: rtl/mem_arbiter.sv
// Shares one single-ported memory between fetch and data requesters; ack two cycles after grant at minimum.
// Requesters stall (StallF/StallM) until their ack; the memory side holds MemReq until MemReady.
module mem_arbiter
    import mips_pkg::*;
#(
    parameter int AW     = 32,
    parameter int DW     = 32,
    parameter int STARVE = STARVE_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          IReq,
    input  logic [AW-1:0] IAddr,
    output logic [DW-1:0] IRdata,
    output logic          IAck,
    input  logic          DReq,
    input  logic          DWe,
    input  logic [AW-1:0] DAddr,
    input  logic [DW-1:0] DWdata,
    output logic [DW-1:0] DRdata,
    output logic          DAck,
    output logic          MemReq,
    output logic          MemWe,
    output logic [AW-1:0] MemAddr,
    output logic [DW-1:0] MemWdata,
    input  logic [DW-1:0] MemRdata,
    input  logic          MemReady,
    output logic          StallF,
    output logic          StallM
);

    localparam int            CW      = $clog2(STARVE + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(STARVE);

    arb_state_t    state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          mem_req_nxt, mem_we_nxt, iack_nxt, dack_nxt;
    logic [AW-1:0] mem_addr_nxt;
    logic [DW-1:0] mem_wdata_nxt, irdata_nxt, drdata_nxt;
    logic          i_elig, d_elig, i_force;

    // A request still high during its own ack cycle is the one just served.
    assign i_elig  = IReq & ~IAck;
    assign d_elig  = DReq & ~DAck;
    assign i_force = i_elig & (cnt == CNT_MAX);

    assign StallF = IReq & ~IAck;
    assign StallM = DReq & ~DAck;

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        mem_req_nxt   = MemReq;
        mem_we_nxt    = MemWe;
        mem_addr_nxt  = MemAddr;
        mem_wdata_nxt = MemWdata;
        irdata_nxt    = IRdata;
        drdata_nxt    = DRdata;
        iack_nxt      = 1'b0;
        dack_nxt      = 1'b0;
        unique case (state)
            ARB_IDLE: begin
                if (d_elig && !i_force) begin
                    state_nxt     = ARB_DBUSY;
                    mem_req_nxt   = 1'b1;
                    mem_we_nxt    = DWe;
                    mem_addr_nxt  = DAddr;
                    mem_wdata_nxt = DWdata;
                    if (!IReq)
                        cnt_nxt = '0;
                    else if (cnt != CNT_MAX)
                        cnt_nxt = cnt + CW'(1);
                end else if (i_elig) begin
                    state_nxt    = ARB_IBUSY;
                    mem_req_nxt  = 1'b1;
                    mem_we_nxt   = 1'b0;
                    mem_addr_nxt = IAddr;
                    cnt_nxt      = '0;
                end
            end
            ARB_IBUSY: begin
                if (MemReady) begin
                    // A fetch withdrawn by a flush still completes on the bus but is not reported.
                    if (IReq) begin
                        irdata_nxt = MemRdata;
                        iack_nxt   = 1'b1;
                    end
                    mem_req_nxt = 1'b0;
                    mem_we_nxt  = 1'b0;
                    state_nxt   = ARB_IDLE;
                end
            end
            ARB_DBUSY: begin
                if (MemReady) begin
                    drdata_nxt  = MemRdata;
                    dack_nxt    = 1'b1;
                    mem_req_nxt = 1'b0;
                    mem_we_nxt  = 1'b0;
                    state_nxt   = ARB_IDLE;
                end
            end
            default: state_nxt = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ARB_IDLE;
            cnt      <= '0;
            MemReq   <= 1'b0;
            MemWe    <= 1'b0;
            MemAddr  <= '0;
            MemWdata <= '0;
            IRdata   <= '0;
            DRdata   <= '0;
            IAck     <= 1'b0;
            DAck     <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            MemReq   <= mem_req_nxt;
            MemWe    <= mem_we_nxt;
            MemAddr  <= mem_addr_nxt;
            MemWdata <= mem_wdata_nxt;
            IRdata   <= irdata_nxt;
            DRdata   <= drdata_nxt;
            IAck     <= iack_nxt;
            DAck     <= dack_nxt;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus random traffic, all checked
// against a transaction-level owner/streak reference model.
module tb_mem_arbiter;

    localparam int AW     = 32;
    localparam int DW     = 32;
    localparam int STARVE = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ireq, dreq, dwe, memready;
    logic [AW-1:0] iaddr, daddr;
    logic [DW-1:0] dwdata, memrdata;
    logic [DW-1:0] IRdata, DRdata, MemWdata;
    logic [AW-1:0] MemAddr;
    logic          IAck, DAck, MemReq, MemWe, StallF, StallM;

    mem_arbiter #(.AW(AW), .DW(DW), .STARVE(STARVE)) dut (
        .clk(clk), .rst(rst),
        .IReq(ireq), .IAddr(iaddr), .IRdata(IRdata), .IAck(IAck),
        .DReq(dreq), .DWe(dwe), .DAddr(daddr), .DWdata(dwdata),
        .DRdata(DRdata), .DAck(DAck),
        .MemReq(MemReq), .MemWe(MemWe), .MemAddr(MemAddr), .MemWdata(MemWdata),
        .MemRdata(memrdata), .MemReady(memready),
        .StallF(StallF), .StallM(StallM)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: who owns the memory (0 none, 1 fetch, 2 data) and how
    // many data grants in a row were made while a fetch was waiting.
    int            m_owner, m_streak;
    bit            m_memreq, m_we, m_iack, m_dack;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata, m_irdata, m_drdata;

    // Memory responder and observation counters.
    int            mem_wait, busy;
    bit            idle_noise, fix_rdata;
    logic [DW-1:0] fix_val;
    int            memreq_cyc, iack_cnt, dack_cnt;
    bit            prev_memreq;
    int            grants[$];

    task automatic model_reset();
        m_owner = 0; m_streak = 0;
        m_memreq = 0; m_we = 0; m_iack = 0; m_dack = 0;
        m_addr = '0; m_wdata = '0; m_irdata = '0; m_drdata = '0;
        busy = 0; prev_memreq = 0;
    endtask

    task automatic clr_obs();
        memreq_cyc = 0; iack_cnt = 0; dack_cnt = 0;
        grants.delete();
    endtask

    task automatic model_next();
        bit ie, de;
        bit n_iack, n_dack;
        n_iack = 0;
        n_dack = 0;
        if (m_owner == 0) begin
            ie = ireq && !m_iack;
            de = dreq && !m_dack;
            if (de && !(ie && m_streak == STARVE)) begin
                m_owner = 2; m_memreq = 1; m_we = dwe; m_addr = daddr; m_wdata = dwdata;
                m_streak = !ireq ? 0 : (m_streak < STARVE ? m_streak + 1 : STARVE);
            end else if (ie) begin
                m_owner = 1; m_memreq = 1; m_we = 0; m_addr = iaddr; m_streak = 0;
            end
        end else if (memready) begin
            if (m_owner == 2) begin
                m_drdata = memrdata; n_dack = 1;
            end else if (ireq) begin
                m_irdata = memrdata; n_iack = 1;
            end
            m_owner = 0; m_memreq = 0; m_we = 0;
        end
        m_iack = n_iack;
        m_dack = n_dack;
    endtask

    task automatic compare_outputs();
        check_eq("mem_req",   MemReq,   m_memreq);
        check_eq("mem_we",    MemWe,    m_we);
        check_eq("mem_addr",  MemAddr,  m_addr);
        check_eq("mem_wdata", MemWdata, m_wdata);
        check_eq("iack",      IAck,     m_iack);
        check_eq("dack",      DAck,     m_dack);
        check_eq("irdata",    IRdata,   m_irdata);
        check_eq("drdata",    DRdata,   m_drdata);
    endtask

    // Called at a falling edge with the requester inputs already set.
    task automatic step();
        bit old_req;
        old_req = m_memreq;
        if (m_memreq) memready = (busy >= mem_wait);
        else          memready = idle_noise ? ($urandom_range(3) == 0) : 1'b0;
        memrdata = fix_rdata ? fix_val : $urandom;
        #1;
        check_eq("stall_f", StallF, ireq & ~m_iack);
        check_eq("stall_m", StallM, dreq & ~m_dack);
        model_next();
        busy = (old_req && !memready) ? busy + 1 : 0;
        @(posedge clk);
        @(negedge clk);
        compare_outputs();
        if (MemReq) memreq_cyc++;
        if (IAck) iack_cnt++;
        if (DAck) dack_cnt++;
        if (MemReq && !prev_memreq) grants.push_back(MemAddr == 32'h80 ? 1 : 2);
        prev_memreq = MemReq;
    endtask

    task automatic do_reset();
        ireq = 0; dreq = 0; dwe = 0;
        rst = 1'b1;
        #1;
        model_reset();
        compare_outputs();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        clr_obs();
    endtask

    initial begin
        ireq = 0; dreq = 0; dwe = 0; iaddr = '0; daddr = '0; dwdata = '0;
        memready = 0; memrdata = '0;
        idle_noise = 0; fix_rdata = 1; fix_val = '0; mem_wait = 0;
        model_reset();
        clr_obs();
        @(negedge clk);
        do_reset();

        // Single read with three wait cycles.
        mem_wait = 3; fix_val = 32'hDEADBEEF;
        dreq = 1; dwe = 0; daddr = 32'h100; dwdata = '0;
        for (int c = 0; c < 12; c++) begin
            if (m_dack) dreq = 0;
            step();
            if (DAck) check_eq("rd_drdata", DRdata, 32'hDEADBEEF);
        end
        check_eq("rd_memreq_cycles", memreq_cyc, 4);
        check_eq("rd_dack_count", dack_cnt, 1);
        check_eq("rd_stallm_idle", StallM, 0);

        // Collision: both rise together, zero-wait memory.
        do_reset();
        mem_wait = 0; fix_val = 32'h0BADF00D;
        ireq = 1; iaddr = 32'h80; dreq = 1; daddr = 32'h40;
        for (int c = 0; c < 12; c++) begin
            if (m_dack) dreq = 0;
            if (m_iack) ireq = 0;
            step();
        end
        check_eq("col_grants", grants.size(), 2);
        if (grants.size() == 2) begin
            check_eq("col_first_is_d", grants[0], 2);
            check_eq("col_second_is_i", grants[1], 1);
        end
        check_eq("col_iack_count", iack_cnt, 1);
        check_eq("col_dack_count", dack_cnt, 1);

        // Starvation: data keeps requesting, fetch waits outside data ack cycles.
        do_reset();
        mem_wait = 0;
        dreq = 1; dwe = 0; daddr = 32'h40; iaddr = 32'h80;
        for (int c = 0; c < 80; c++) begin
            ireq = !m_dack;
            step();
            if (grants.size() >= 10) break;
        end
        check_eq("starve_grants", grants.size(), 10);
        for (int g = 0; g < 10 && g < grants.size(); g++)
            check_eq($sformatf("starve_grant%0d", g), grants[g], (g == 4 || g == 9) ? 1 : 2);
        dreq = 0; ireq = 0;
        for (int c = 0; c < 4; c++) step();

        // Flush: fetch withdrawn one cycle after grant, memory waits two cycles.
        do_reset();
        mem_wait = 2; fix_val = 32'hBAD0BAD0;
        ireq = 1; iaddr = 32'h80;
        step();
        ireq = 0;
        for (int c = 0; c < 8; c++) step();
        check_eq("flush_memreq_cycles", memreq_cyc, 3);
        check_eq("flush_no_iack", iack_cnt, 0);
        check_eq("flush_irdata_kept", IRdata, 0);

        // Reset in the middle of a data transaction.
        do_reset();
        mem_wait = 6; fix_val = 32'h5A5A5A5A;
        dreq = 1; dwe = 0; daddr = 32'h40;
        for (int c = 0; c < 3; c++) step();
        check_eq("rst_busy_before", MemReq, 1);
        rst = 1'b1;
        #1;
        check_eq("rst_memreq_drop", MemReq, 0);
        check_eq("rst_dack_low", DAck, 0);
        check_eq("rst_iack_low", IAck, 0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        step();
        check_eq("rst_regrant", MemReq, 1);
        for (int c = 0; c < 12; c++) begin
            if (m_dack) dreq = 0;
            step();
        end

        // Store with two wait cycles.
        do_reset();
        mem_wait = 2; fix_val = 32'hFFFF0000;
        dreq = 1; dwe = 1; daddr = 32'h20; dwdata = 32'h12345678;
        for (int c = 0; c < 8; c++) begin
            if (m_dack) dreq = 0;
            step();
            if (MemReq) begin
                check_eq("st_we", MemWe, 1);
                check_eq("st_addr", MemAddr, 32'h20);
                check_eq("st_wdata", MemWdata, 32'h12345678);
            end
        end
        check_eq("st_memreq_cycles", memreq_cyc, 3);
        check_eq("st_dack_count", dack_cnt, 1);

        // Random traffic with flushes, variable latency and stray MemReady.
        do_reset();
        idle_noise = 1; fix_rdata = 0;
        for (int c = 0; c < 3000; c++) begin
            if (!dreq || m_dack) begin
                dreq = ($urandom_range(2) == 0);
                dwe = $urandom_range(1);
                daddr = $urandom;
                dwdata = $urandom;
            end
            if (!ireq || m_iack) begin
                ireq = ($urandom_range(2) == 0);
                iaddr = $urandom;
            end else if ($urandom_range(15) == 0) begin
                ireq = 0;
            end
            if (!m_memreq) mem_wait = $urandom_range(3);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
